scp_light_conditioner: RTL
==========================

// Module: scp_light_conditioner
// PURPOSE
//   Upstream stage of the scp_079 containment controller.
//   Takes raw, asynchronous green/yellow/red indicator lines, synchronises and debounces each one,
//   and drives scp_079's green/yellow/red inputs with a clean, registered, strictly one-hot colour.
//   Flags illegal multi-colour input so downstream logic never sees more than one colour asserted.
// PARAMETERS
//   DEBOUNCE_CYCLES  3  consecutive clock edges a synced input must differ from its stable value before it is accepted (>=1)
//   CNT_W            4  debounce counter width; 2**CNT_W must be > DEBOUNCE_CYCLES
// PORTS
//   clock       in   1  system clock; all state changes on the rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   raw_green   in   1  unsynchronised green indicator
//   raw_yellow  in   1  unsynchronised yellow indicator
//   raw_red     in   1  unsynchronised red indicator
//   green       out  1  clean green level to scp_079
//   yellow      out  1  clean yellow level to scp_079
//   red         out  1  clean red level to scp_079
//   fault       out  1  high while two or more debounced channels are high
//   change      out  1  one-cycle pulse when the output colour changes
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low. Clock port is clock, reset port is reset_n.
//   Reset (reset_n=0, takes effect immediately, no clock edge needed):
//     - Sync flops, stable values and counters clear to 0.
//     - FSM goes to S_RED.
//     - Outputs: red=1, green=0, yellow=0, fault=0, change=0.
//     - Reset asserted mid-debounce discards any partial count.
//   Synchroniser: 2-flop chain per channel. sN is raw delayed 2 edges.
//   Debounce, per channel; evaluated each edge:
//     - s==stable: cnt<=0.
//     - s!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0.
//     - Otherwise cnt<=cnt+1.
//     - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches stable; the count restarts from 0.
//   Colour FSM (states S_GREEN, S_YELLOW, S_RED); next state from debounced vector {r,y,g}:
//     - Exactly one bit high: go to that colour.
//     - None high: hold current state (last valid colour persists).
//     - Two or more high: priority red > yellow > green, and fault=1 for every cycle this holds.
//     - fault drops on the first cycle the debounced vector is legal again.
//   Outputs are registered and decoded one-hot from state; exactly one of green/yellow/red is 1 at all times.
//   change: registered, 1 for exactly one cycle on the edge where state differs from the previous state. Never asserted out of reset.
//   Latency: a clean raw edge set up before rising edge 1 updates stable at edge 2+DEBOUNCE_CYCLES.
//     Outputs change at edge 3+DEBOUNCE_CYCLES (edge 6 for the default).
//   Simultaneous input changes: each channel is debounced independently. The FSM may pass through a fault cycle if the channels settle on different edges.
//   Counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
// TESTING
//   1. Reset: assert reset_n=0 between edges
//      -> red=1, green=0, yellow=0, fault=0, change=0 immediately, without a clock edge.
//   2. Clean switch: from red, set raw_red=0 and raw_green=1 before edge 1 (DEBOUNCE_CYCLES=3)
//      -> green=1, red=0 and change=1 at edge 6; change=0 at edge 7.
//   3. Glitch: with stable green, pulse raw_yellow=1 for 2 clock periods
//      -> outputs stay green, fault=0, change never asserts.
//   4. Conflict: raw_green=1 and raw_yellow=1 held
//      -> after debounce yellow=1 and fault=1.
//      -> Then drop raw_yellow: green=1 and fault=0 at 3+DEBOUNCE_CYCLES edges after the drop.
//   5. All off: from yellow, drop all raw lines for 20 cycles
//      -> yellow stays 1, fault=0, change=0.
//   6. Reset mid-debounce: raw_red rises, reset_n pulses low after 2 edges, then is released with raw_red held
//      -> red stays 1 throughout (reset state).
//      -> Outputs follow the full DEBOUNCE_CYCLES+3 latency again from the release.

Source files
------------

// File: rtl/scp_light_conditioner.sv
// rtl/scp_light_conditioner.sv - synchronise, debounce and one-hot encode raw colour indicators
//
// Purpose: cleans three asynchronous indicator lines into a strictly one-hot
// registered colour for the scp_079 containment controller, flagging any
// multi-colour condition on the debounced inputs.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   raw_green   in   unsynchronised green indicator
//   raw_yellow  in   unsynchronised yellow indicator
//   raw_red     in   unsynchronised red indicator
//   green       out  clean green level
//   yellow      out  clean yellow level
//   red         out  clean red level
//   fault       out  high while two or more debounced channels are high
//   change      out  one-cycle pulse when the output colour changes

module scp_light_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_green,
  input  logic raw_yellow,
  input  logic raw_red,
  output logic green,
  output logic yellow,
  output logic red,
  output logic fault,
  output logic change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // One-hot state encoding so the colour outputs come straight off flops.
  typedef enum logic [2:0] {
    S_GREEN  = 3'b001,
    S_YELLOW = 3'b010,
    S_RED    = 3'b100
  } state_e;

  logic [2:0] raw_vec;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] stable_vec;

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   change_q, change_d;

  // Channel order {red, yellow, green}.
  assign raw_vec = {raw_red, raw_yellow, raw_green};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter restarts whenever the synced value agrees with the stable
    // value, so a glitch shorter than DEBOUNCE_CYCLES never gets through.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (sync2_q[i] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q[i];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stable_vec[i] = stable_q;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RED;
      fault_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      change_q <= change_d;
    end
  end

  // Next-state logic: all-off holds the last colour; conflicts resolve
  // red > yellow > green and raise fault for as long as they persist.
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    case (stable_vec)
      3'b000: state_d = state_q;
      3'b001: state_d = S_GREEN;
      3'b010: state_d = S_YELLOW;
      3'b100: state_d = S_RED;
      default: begin
        fault_d = 1'b1;
        state_d = stable_vec[2] ? S_RED : S_YELLOW;
      end
    endcase
    change_d = (state_d != state_q);
  end

  // Output decode.
  always_comb begin
    green  = state_q[0];
    yellow = state_q[1];
    red    = state_q[2];
    fault  = fault_q;
    change = change_q;
  end

endmodule
